fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the 8-deep byte FIFO between NUM_REQ producers.
- Uses round-robin arbitration with bounded bursts.
- Each producer has a valid/ready handshake. The arbiter drives the FIFO wr/data_in pins and respects the FIFO full flag.
- Sits in the FIFO write-clock domain, directly in front of the FIFO write side.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_arb_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and the other FIFO-side schedulers.
// Optional feature macro used by this slice: FIFO_ARB_PRIO_EN (requester 0 priority).
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    localparam int unsigned GRANT_W = 3;
    localparam int unsigned MAX_REQ = 1 << GRANT_W;

    function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                   input int unsigned        num_req);
        if (idx >= GRANT_W'(num_req - 1)) begin
            return '0;
        end
        return idx + GRANT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: first set request after last_owner, wrapping modulo NUM_REQ.
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_owner,
    output logic [GRANT_W-1:0] winner,
    output logic               any_valid
);

    logic [MAX_REQ-1:0] req_pad;
    logic [GRANT_W-1:0] idx;
    logic               found;

    always_comb begin
        req_pad                = '0;
        req_pad[NUM_REQ-1:0]   = req;
        winner                 = '0;
        found                  = 1'b0;
        idx                    = last_owner;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = rr_next(idx, NUM_REQ);
            if (!found && req_pad[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        any_valid = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded sharing of the FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_PRIO_EN to give requester 0 priority at every arbitration.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_data,
    output logic [GRANT_W-1:0]        grant_id,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GRANT_W-1:0] pick;
    logic               pick_any;
    logic [MAX_REQ-1:0] valid_pad;
    logic [DATA_W-1:0]  data_arr [MAX_REQ];
    logic               owner_valid;

    always_comb begin
        valid_pad              = '0;
        valid_pad[NUM_REQ-1:0] = req_valid;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            data_arr[i] = '0;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

`ifdef FIFO_ARB_PRIO_EN
    logic [NUM_REQ-1:0] rr_req;
    logic [GRANT_W-1:0] rr_win;
    logic               rr_any;

    // Requester 0 is removed from the rotation so the others keep their own fairness.
    assign rr_req = req_valid & ~NUM_REQ'(1);

    fifo_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (rr_req),
        .last_owner (last_q),
        .winner     (rr_win),
        .any_valid  (rr_any)
    );

    assign pick     = req_valid[0] ? '0 : rr_win;
    assign pick_any = req_valid[0] | rr_any;
`else
    fifo_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req_valid),
        .last_owner (last_q),
        .winner     (pick),
        .any_valid  (pick_any)
    );
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            last_q  <= GRANT_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        req_ready   = '0;
        fifo_wr     = 1'b0;
        fifo_data   = '0;
        owner_valid = valid_pad[grant_q];

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // Outputs are suppressed on a reset edge so an abandoned burst never writes.
                if (reset_n) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        req_ready[i] = (grant_q == GRANT_W'(i)) && !fifo_full;
                    end
                    fifo_wr = owner_valid && !fifo_full;
                end
                if (fifo_wr) begin
                    fifo_data = data_arr[grant_q];
                end
                if (!owner_valid) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                end else if (fifo_wr) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d = ARB_IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign busy     = (state_q == ARB_GRANT);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus round-robin/priority burst sequences.
module tb_fifo_wr_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BURST = 4;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr;
    logic [DATA_W-1:0]         fifo_data;
    logic [2:0]                grant_id;
    logic                      busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        full;
        logic [3:0]  ready;
        logic        wr;
        logic [7:0]  fdata;
        logic        busy;
        logic [2:0]  gid;
    } vec_t;

    vec_t vecs [25];

    function automatic logic [31:0] pk(input logic [7:0] b3, input logic [7:0] b2,
                                       input logic [7:0] b1, input logic [7:0] b0);
        return {b3, b2, b1, b0};
    endfunction

    function automatic vec_t mk(input logic rst_n, input logic [3:0] valid, input logic [31:0] data,
                                input logic full, input logic [3:0] ready, input logic wr,
                                input logic [7:0] fdata, input logic bsy, input logic [2:0] gid);
        vec_t v;
        v.rst_n = rst_n; v.valid = valid; v.data = data; v.full = full;
        v.ready = ready; v.wr = wr; v.fdata = fdata; v.busy = bsy; v.gid = gid;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
    endtask

    // Starts in a bubble cycle; checks n grants of MAX_BURST beats each with continuous valid.
    task automatic run_grants(input string tag, input logic [2:0] ord [5], input int n,
                              input logic [7:0] base);
        for (int g = 0; g < n; g++) begin
            #1;
            check($sformatf("%s g%0d bubble busy", tag, g), 32'(busy), 32'd0);
            check($sformatf("%s g%0d bubble wr", tag, g), 32'(fifo_wr), 32'd0);
            for (int b = 0; b < int'(MAX_BURST); b++) begin
                @(negedge clk);
                #1;
                check($sformatf("%s g%0d b%0d gid", tag, g, b), 32'(grant_id), 32'(ord[g]));
                check($sformatf("%s g%0d b%0d wr", tag, g, b), 32'(fifo_wr), 32'd1);
                check($sformatf("%s g%0d b%0d data", tag, g, b), 32'(fifo_data),
                      32'(base + 8'(ord[g])));
                check($sformatf("%s g%0d b%0d ready", tag, g, b), 32'(req_ready),
                      32'(4'b0001 << ord[g]));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [2:0] ord_all  [5];
        logic [2:0] ord_prio [5];

        vecs[0]  = mk(0, 4'b0000, pk(8'h00, 8'h00, 8'h00, 8'h00), 0, 4'b0000, 0, 8'h00, 0, 3'd0);
        vecs[1]  = mk(1, 4'b0100, pk(8'hA3, 8'h10, 8'hA1, 8'hA0), 0, 4'b0000, 0, 8'h00, 0, 3'd0);
        vecs[2]  = mk(1, 4'b0100, pk(8'hA3, 8'h10, 8'hA1, 8'hA0), 0, 4'b0100, 1, 8'h10, 1, 3'd2);
        vecs[3]  = mk(1, 4'b0100, pk(8'hA3, 8'h11, 8'hA1, 8'hA0), 0, 4'b0100, 1, 8'h11, 1, 3'd2);
        vecs[4]  = mk(1, 4'b0100, pk(8'hA3, 8'h12, 8'hA1, 8'hA0), 0, 4'b0100, 1, 8'h12, 1, 3'd2);
        vecs[5]  = mk(1, 4'b0100, pk(8'hA3, 8'h13, 8'hA1, 8'hA0), 0, 4'b0100, 1, 8'h13, 1, 3'd2);
        vecs[6]  = mk(1, 4'b0000, pk(8'hA3, 8'h13, 8'hA1, 8'hA0), 0, 4'b0000, 0, 8'h00, 0, 3'd0);
        vecs[7]  = mk(1, 4'b0010, pk(8'hB3, 8'hB2, 8'h21, 8'hB0), 0, 4'b0000, 0, 8'h00, 0, 3'd0);
        vecs[8]  = mk(1, 4'b0010, pk(8'hB3, 8'hB2, 8'h21, 8'hB0), 0, 4'b0010, 1, 8'h21, 1, 3'd1);
        vecs[9]  = mk(1, 4'b0010, pk(8'hB3, 8'hB2, 8'h22, 8'hB0), 0, 4'b0010, 1, 8'h22, 1, 3'd1);
        vecs[10] = mk(1, 4'b0010, pk(8'hB3, 8'hB2, 8'h23, 8'hB0), 1, 4'b0000, 0, 8'h00, 1, 3'd1);
        vecs[11] = mk(1, 4'b0010, pk(8'hB3, 8'hB2, 8'h23, 8'hB0), 1, 4'b0000, 0, 8'h00, 1, 3'd1);
        vecs[12] = mk(1, 4'b0010, pk(8'hB3, 8'hB2, 8'h23, 8'hB0), 1, 4'b0000, 0, 8'h00, 1, 3'd1);
        vecs[13] = mk(1, 4'b0010, pk(8'hB3, 8'hB2, 8'h23, 8'hB0), 0, 4'b0010, 1, 8'h23, 1, 3'd1);
        vecs[14] = mk(1, 4'b0010, pk(8'hB3, 8'hB2, 8'h24, 8'hB0), 0, 4'b0010, 1, 8'h24, 1, 3'd1);
        vecs[15] = mk(1, 4'b0000, pk(8'hB3, 8'hB2, 8'h24, 8'hB0), 0, 4'b0000, 0, 8'h00, 0, 3'd0);
        vecs[16] = mk(1, 4'b1000, pk(8'h31, 8'hC2, 8'hC1, 8'hC0), 0, 4'b0000, 0, 8'h00, 0, 3'd0);
        vecs[17] = mk(1, 4'b1000, pk(8'h31, 8'hC2, 8'hC1, 8'hC0), 0, 4'b1000, 1, 8'h31, 1, 3'd3);
        vecs[18] = mk(1, 4'b0000, pk(8'h32, 8'hC2, 8'hC1, 8'hC0), 0, 4'b1000, 0, 8'h00, 1, 3'd3);
        vecs[19] = mk(1, 4'b1111, pk(8'h43, 8'h42, 8'h41, 8'h40), 0, 4'b0000, 0, 8'h00, 0, 3'd0);
        vecs[20] = mk(1, 4'b1111, pk(8'h43, 8'h42, 8'h41, 8'h40), 0, 4'b0001, 1, 8'h40, 1, 3'd0);
        vecs[21] = mk(1, 4'b1111, pk(8'h43, 8'h42, 8'h41, 8'h51), 0, 4'b0001, 1, 8'h51, 1, 3'd0);
        vecs[22] = mk(0, 4'b1111, pk(8'h43, 8'h42, 8'h41, 8'h52), 0, 4'b0000, 0, 8'h00, 1, 3'd0);
        vecs[23] = mk(1, 4'b1111, pk(8'h43, 8'h42, 8'h41, 8'h52), 0, 4'b0000, 0, 8'h00, 0, 3'd0);
        vecs[24] = mk(1, 4'b1111, pk(8'h43, 8'h42, 8'h41, 8'h52), 0, 4'b0001, 1, 8'h52, 1, 3'd0);

        ord_all = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
`ifdef FIFO_ARB_PRIO_EN
        ord_prio = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`else
        ord_prio = '{3'd0, 3'd2, 3'd0, 3'd2, 3'd0};
`endif

        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            reset_n   = vecs[i].rst_n;
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            fifo_full = vecs[i].full;
            #1;
            check($sformatf("v%0d ready", i), 32'(req_ready), 32'(vecs[i].ready));
            check($sformatf("v%0d wr", i), 32'(fifo_wr), 32'(vecs[i].wr));
            check($sformatf("v%0d data", i), 32'(fifo_data), 32'(vecs[i].fdata));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            if (vecs[i].busy || !vecs[i].rst_n) begin
                check($sformatf("v%0d gid", i), 32'(grant_id), 32'(vecs[i].gid));
            end
        end

        do_reset();
        req_valid = 4'b1111;
        req_data  = pk(8'h63, 8'h62, 8'h61, 8'h60);
        run_grants("rr", ord_all, 5, 8'h60);

        do_reset();
        req_valid = 4'b0101;
        req_data  = pk(8'h73, 8'h72, 8'h71, 8'h70);
        run_grants("prio", ord_prio, 4, 8'h70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
